// File: rtl/alu_seq_ctrl.sv
// Sequential ALU that processes operands two bits per cycle, LSB slice first.
// Optional zero flag output enabled by defining ALU_SEQ_ZERO_FLAG_EN.
module alu_seq_ctrl #(
    parameter int unsigned NSLICE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [2*NSLICE-1:0]   a,
    input  logic [2*NSLICE-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [2*NSLICE-1:0]   result,
    output logic                  carry
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic                  zero
`endif
);

    localparam int unsigned W  = 2 * NSLICE;
    localparam int unsigned CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic [W-1:0]    a_q, a_nxt, b_q, b_nxt;
    logic [2:0]      op_q, op_nxt;
    logic            c_q, c_nxt;
    logic [W-1:0]    result_nxt;
    logic            carry_nxt;
    logic [1:0]      a_sl, b_sl, slice;
    logic [2:0]      sum3, diff3;
    logic            cout;
    logic            last;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic            zero_nxt;
`endif

    // Current slice arithmetic; c_q is carry for add and borrow for sub.
    always_comb begin
        a_sl  = 2'(a_q >> {cnt_q, 1'b0});
        b_sl  = 2'(b_q >> {cnt_q, 1'b0});
        sum3  = 3'(a_sl) + 3'(b_sl) + 3'(c_q);
        diff3 = 3'(a_sl) - 3'(b_sl) - 3'(c_q);
        last  = (cnt_q == CW'(NSLICE - 1));
        slice = 2'b00;
        cout  = 1'b0;
        case (op_q)
            OP_ADD: begin slice = sum3[1:0];  cout = sum3[2];  end
            OP_SUB: begin slice = diff3[1:0]; cout = diff3[2]; end
            OP_AND: slice = a_sl & b_sl;
            OP_OR:  slice = a_sl | b_sl;
            OP_XOR: slice = a_sl ^ b_sl;
            default: ;
        endcase
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        a_nxt      = a_q;
        b_nxt      = b_q;
        op_nxt     = op_q;
        c_nxt      = c_q;
        result_nxt = result;
        carry_nxt  = carry;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        zero_nxt   = zero;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt  = RUN;
                    a_nxt      = a;
                    b_nxt      = b;
                    op_nxt     = op;
                    cnt_nxt    = '0;
                    c_nxt      = 1'b0;
                    result_nxt = '0;
                    carry_nxt  = 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                    zero_nxt   = 1'b0;
`endif
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NSLICE; i++) begin
                    if (cnt_q == CW'(i)) result_nxt[2*i +: 2] = slice;
                end
                c_nxt = cout;
                if (last) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                    carry_nxt = cout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                    zero_nxt  = (result_nxt == '0);
`endif
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            c_q     <= 1'b0;
            result  <= '0;
            carry   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero    <= 1'b0;
`endif
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            op_q    <= op_nxt;
            c_q     <= c_nxt;
            result  <= result_nxt;
            carry   <= carry_nxt;
            busy    <= (state_nxt == RUN);
            done    <= (state_nxt == DONE);
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero    <= zero_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized and directed bench for alu_seq_ctrl against a whole-word arithmetic model.
module tb_alu_seq_ctrl;

    localparam int unsigned NSLICE = 4;
    localparam int unsigned W      = 2 * NSLICE;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, carry;
    logic [W-1:0] result;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic         zero;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.NSLICE(NSLICE)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry)
`ifdef ALU_SEQ_ZERO_FLAG_EN
        ,
        .zero   (zero)
`endif
    );

    // Whole-word reference: the sliced ALU must match plain W-bit arithmetic.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic c);
        logic [W:0] s;
        r = '0;
        c = 1'b0;
        case (o)
            3'd0: begin s = {1'b0, x} + {1'b0, y}; r = s[W-1:0]; c = s[W]; end
            3'd1: begin r = x - y; c = (x < y); end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            default: ;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation; returns in the done cycle with start left low.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit noisy, input string tag,
                         output logic [W-1:0] er, output logic ec);
        model(o, x, y, er, ec);
        start = 1'b1; op = o; a = x; b = y;
        tick();
        for (int k = 0; k < int'(NSLICE); k++) begin
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s run cycle %0d: busy=%b done=%b, expected busy=1 done=0", tag, k, busy, done);
            end
            if (noisy) begin
                start = 1'($urandom); op = 3'($urandom); a = W'($urandom); b = W'($urandom);
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done cycle: busy=%b done=%b, expected busy=0 done=1", tag, busy, done);
        end
        n_checks++;
        if (result !== er || carry !== ec) begin
            n_fail++;
            $display("FAIL %s result: got %h carry %b, expected %h carry %b (op=%0d a=%h b=%h)",
                     tag, result, carry, er, ec, o, x, y);
        end
`ifdef ALU_SEQ_ZERO_FLAG_EN
        n_checks++;
        if (zero !== (er == '0)) begin
            n_fail++;
            $display("FAIL %s zero: got %b, expected %b", tag, zero, (er == '0));
        end
`endif
    endtask

    // One cycle with start low after done: idle, no second pulse, outputs held.
    task automatic idle_check(input logic [W-1:0] er, input logic ec, input string tag);
        start = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== er || carry !== ec) begin
            n_fail++;
            $display("FAIL %s hold: busy=%b done=%b result=%h carry=%b, expected 0 0 %h %b",
                     tag, busy, done, result, carry, er, ec);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        #2;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || carry !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b result=%h carry=%b, expected all 0", busy, done, result, carry);
        end
        tick();
        tick();
        rst = 1'b0;
        idle_check('0, 1'b0, "reset_idle");
    endtask

    task automatic test_add();
        logic [W-1:0] r; logic c;
        do_op(3'd0, 8'hFF, 8'h01, 1'b0, "add_ff_01", r, c);
        idle_check(r, c, "add_ff_01");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r; logic c;
        do_op(3'd1, 8'h10, 8'h20, 1'b0, "sub_10_20", r, c);
        do_op(3'd1, 8'h20, 8'h10, 1'b0, "sub_20_10_b2b", r, c);
        idle_check(r, c, "sub_20_10_b2b");
    endtask

    task automatic test_logic();
        logic [W-1:0] r; logic c;
        do_op(3'd2, 8'hCC, 8'hAA, 1'b0, "and", r, c);  idle_check(r, c, "and");
        do_op(3'd4, 8'hCC, 8'hAA, 1'b0, "xor", r, c);  idle_check(r, c, "xor");
        do_op(3'd3, 8'hCC, 8'hAA, 1'b0, "or", r, c);   idle_check(r, c, "or");
        do_op(3'd7, 8'hCC, 8'hAA, 1'b0, "inv7", r, c); idle_check(r, c, "inv7");
        do_op(3'd5, 8'hFF, 8'hFF, 1'b0, "inv5", r, c); idle_check(r, c, "inv5");
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] r; logic c;
        do_op(3'd0, 8'h5A, 8'h3C, 1'b1, "ignore_start", r, c);
        idle_check(r, c, "ignore_start");
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] r; logic c;
        start = 1'b1; op = 3'd0; a = 8'h77; b = 8'h11;
        tick();
        start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || carry !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_run_reset: busy=%b done=%b result=%h carry=%b, expected all 0",
                     busy, done, result, carry);
        end
        #1 rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_run_reset cycle %0d: busy=%b done=%b, expected 0 0", k, busy, done);
            end
        end
        do_op(3'd0, 8'h03, 8'h05, 1'b0, "after_reset", r, c);
        idle_check(r, c, "after_reset");
    endtask

    task automatic test_random();
        logic [W-1:0] r; logic c;
        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom), "random", r, c);
            if ($urandom_range(0, 1) == 0) idle_check(r, c, "random");
        end
        idle_check(r, c, "random_end");
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_logic();
        test_ignore_start();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NSLICE, default 4, giving the number of 2-bit slices per operation; operand width W = 2*NSLICE, NSLICE >= 1.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request to begin an operation; sampled on rising edge of clk.
REQ-005 The block SHALL have port op  input  3  operation select: 000 add, 001 sub, 010 AND, 011 OR, 100 XOR, 101-111 invalid.
REQ-006 The block SHALL have ports a, b  input  W  operands, sampled only when start is accepted.
REQ-007 The block SHALL have port busy  output  1  high while slices are being processed.
REQ-008 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 The block SHALL have port result  output  W  registered result.
REQ-010 The block SHALL have port carry  output  1  registered carry-out (add) or borrow (sub).

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE.
REQ-012 In IDLE or DONE, start=1 SHALL be accepted: latch a, b, op; clear slice counter and internal carry/borrow; clear result; go to RUN.
REQ-013 In RUN, start SHALL be ignored; a, b and op SHALL not affect the operation in flight.
REQ-014 Each RUN cycle SHALL process exactly one 2-bit slice, LSB first (slice i = bits 2i+1:2i), writing that slice of result and updating internal carry/borrow.
REQ-015 Add slice SHALL be a_i + b_i + c; sub slice SHALL be a_i - b_i - borrow; logic ops SHALL be bitwise on the slice with no carry.
REQ-016 After slice NSLICE-1, the FSM SHALL go to DONE; carry SHALL be the carry out of bit W-1 for add, 1 iff a < b (unsigned) for sub, 0 for logic and invalid ops.
REQ-017 Invalid op SHALL yield result 0 and carry 0 and SHALL still take NSLICE RUN cycles.
REQ-018 Latency: start accepted at edge t -> busy=1 for the cycles following edges t..t+NSLICE-1; done=1 for exactly the cycle following edge t+NSLICE; busy=0 during done.
REQ-019 DONE SHALL last one cycle, returning to IDLE if start=0, or to RUN (back-to-back, no idle gap) if start=1.
REQ-020 result and carry SHALL hold their final values from DONE until the next accepted start.
REQ-021 Slice counter SHALL be wide enough for NSLICE and SHALL not wrap inside an operation.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, counter 0, busy=0, done=0, result=0, carry=0, independent of clk.
REQ-023 Reset mid-RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-024 Macro ALU_SEQ_ZERO_FLAG_EN defined SHALL add port zero  output  1, registered, set in DONE to 1 iff result == 0, held with result, reset to 0.
REQ-025 Without ALU_SEQ_ZERO_FLAG_EN, port zero and its logic SHALL be absent; all other behaviour identical.

Verification (NSLICE=4, W=8)
REQ-026 start, op=000, a=0xFF, b=0x01 -> busy 4 cycles, done pulse 5th cycle, result=0x00, carry=1, zero=1 if enabled.
REQ-027 op=001, a=0x10, b=0x20 -> result=0xF0, carry=1; then op=001, a=0x20, b=0x10 back-to-back via start in DONE -> result=0x10, carry=0, no idle gap.
REQ-028 op=010, a=0xCC, b=0xAA -> result=0x88, carry=0; op=100, same operands -> result=0x66; op=111 -> result=0x00, carry=0.
REQ-029 start during RUN with different a/b/op -> ignored; first result unchanged, exactly one done pulse.
REQ-030 rst asserted between clock edges during 2nd RUN cycle -> outputs 0 immediately, no done; next start op=000, a=0x03, b=0x05 -> result=0x08, carry=0.
